// File: rtl/ped_request_unit_if.sv
// Pedestrian request bus: buttons in, request/grant handshake,
// and button indicator LEDs out.
interface ped_request_unit_if #(
  parameter int N_CH = 3
);
  logic            en;
  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] led_green;
  logic [N_CH-1:0] led_red;

  modport master (
    output en,
    output btn_raw,
    output grant,
    input  req,
    input  led_green,
    input  led_red
  );

  modport slave (
    input  en,
    input  btn_raw,
    input  grant,
    output req,
    output led_green,
    output led_red
  );
endinterface

// File: rtl/ped_request_unit.sv
// Pedestrian button conditioning, request latching and LED drive.
// One sync/debounce/FSM lane per channel, shared blink generator.
module ped_request_unit #(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int BLINK_HALF      = 2500
) (
  input logic CLK,
  input logic reset,
  ped_request_unit_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLK_TOP = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } st_t;

  logic [BW-1:0] bcnt;
  logic          blink;
  logic          wrap;
  logic          blink_nxt;

  assign wrap      = (bcnt == BLK_TOP);
  assign blink_nxt = wrap ? ~blink : blink;

  // Free-running blink phase, independent of en.
  always_ff @(posedge CLK) begin
    if (reset) begin
      bcnt  <= '0;
      blink <= 1'b1;
    end else begin
      bcnt  <= wrap ? '0 : bcnt + 1'b1;
      blink <= blink_nxt;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;
    logic          press;
    st_t           st;
    st_t           st_nxt;
    logic          req_q;
    logic          green_q;
    logic          red_q;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge CLK) begin
      if (reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= bus.btn_raw[i];
        s2 <= s1;
      end
    end

    // Accept a level change only after enough consecutive samples.
    always_ff @(posedge CLK) begin
      if (reset) begin
        db   <= 1'b0;
        db_q <= 1'b0;
        cnt  <= '0;
      end else begin
        db_q <= db;
        if (s2 == db) begin
          cnt <= '0;
        end else if (cnt == CNT_TOP) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press = db & ~db_q;

    // Next channel state; a grant outranks a coincident press.
    always_comb begin
      st_nxt = st;
      if (!bus.en) begin
        st_nxt = IDLE;
      end else begin
        unique case (st)
          IDLE: begin
            if (bus.grant[i])
              st_nxt = SERVING;
            else if (press)
              st_nxt = PENDING;
          end
          PENDING: begin
            if (bus.grant[i])
              st_nxt = SERVING;
          end
          SERVING: begin
            if (!bus.grant[i])
              st_nxt = IDLE;
          end
          default: st_nxt = IDLE;
        endcase
      end
    end

    // Channel state and its registered indicator outputs.
    always_ff @(posedge CLK) begin
      if (reset) begin
        st      <= IDLE;
        req_q   <= 1'b0;
        green_q <= 1'b0;
        red_q   <= 1'b1;
      end else begin
        st      <= st_nxt;
        req_q   <= (st_nxt == PENDING);
        green_q <= (st_nxt == SERVING);
        unique case (st_nxt)
          PENDING: red_q <= blink_nxt;
          SERVING: red_q <= 1'b0;
          default: red_q <= 1'b1;
        endcase
      end
    end

    assign bus.req[i]       = req_q;
    assign bus.led_green[i] = green_q;
    assign bus.led_red[i]   = red_q;
  end

endmodule

// File: tb/tb_ped_request_unit.sv
// Scoreboard bench for ped_request_unit: directed scenarios then
// random stimulus against a window/phase based reference model.
module tb_ped_request_unit;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int BH = 3;

  logic CLK;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ped_request_unit_if #(.N_CH(N)) bus ();

  ped_request_unit #(
    .N_CH(N),
    .DEBOUNCE_CYCLES(D),
    .BLINK_HALF(BH)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef logic [3*N-1:0] exp_t;
  exp_t exp_q[$];

  // reference model state
  bit m_s1[N];
  bit m_s2[N];
  bit m_db[N];
  bit m_press[N];
  bit m_pend[N];
  bit m_serv[N];
  bit m_win[N][$];
  int m_k;

  // Model: sync is a 2-sample delay, db flips when the last D
  // samples all disagree with it, blink phase = floor(k/BH) parity.
  always @(posedge CLK) begin
    exp_t e;
    bit   blink;
    bit   all_diff;
    bit   old;
    if (reset) begin
      m_k = 0;
      for (int c = 0; c < N; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0;
        m_press[c] = 0; m_pend[c] = 0; m_serv[c] = 0;
        m_win[c].delete();
      end
    end else begin
      m_k++;
      for (int c = 0; c < N; c++) begin
        if (!bus.en) begin
          m_pend[c] = 0; m_serv[c] = 0;
        end else if (bus.grant[c]) begin
          m_serv[c] = 1; m_pend[c] = 0;
        end else if (m_serv[c]) begin
          m_serv[c] = 0;
        end else if (m_press[c]) begin
          m_pend[c] = 1;
        end
        m_win[c].push_back(m_s2[c]);
        if (m_win[c].size() > D) void'(m_win[c].pop_front());
        old = m_db[c];
        all_diff = (m_win[c].size() == D);
        foreach (m_win[c][j]) if (m_win[c][j] == m_db[c]) all_diff = 0;
        if (all_diff) begin
          m_db[c] = !m_db[c];
          m_win[c].delete();
        end
        m_press[c] = m_db[c] && !old;
        m_s2[c] = m_s1[c];
        m_s1[c] = bus.btn_raw[c];
      end
    end
    blink = ((m_k / BH) % 2) == 0;
    for (int c = 0; c < N; c++) begin
      e[2*N + c] = m_pend[c];
      e[N + c]   = m_serv[c];
      e[c]       = m_serv[c] ? 1'b0 : (m_pend[c] ? blink : 1'b1);
    end
    exp_q.push_back(e);
  end

  // Monitor: outputs are valid every cycle, compare one entry per edge.
  initial begin
    exp_t e;
    exp_t a;
    @(posedge CLK);
    forever begin
      #1;
      a = {bus.req, bus.led_green, bus.led_red};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t actual=%b", $time, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t req/grn/red actual=%b_%b_%b required=%b_%b_%b",
                   $time, a[3*N-1:2*N], a[2*N-1:N], a[N-1:0],
                   e[3*N-1:2*N], e[2*N-1:N], e[N-1:0]);
        end
      end
      @(posedge CLK);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    reset       = 1'b1;
    bus.en      = 1'b1;
    bus.btn_raw = '0;
    bus.grant   = '0;
    step(3);
    reset = 1'b0;

    // press on ch0 held, 3-sample glitch on ch1
    bus.btn_raw[0] = 1'b1;
    bus.btn_raw[1] = 1'b1;
    step(3);
    bus.btn_raw[1] = 1'b0;
    step(12);

    // ch2 request then 5-cycle grant
    bus.btn_raw[2] = 1'b1;
    step(9);
    bus.grant[2] = 1'b1;
    step(5);
    bus.grant[2] = 1'b0;
    step(4);
    bus.btn_raw[2] = 1'b0;
    step(8);

    // press event and grant on the same edge on ch1
    bus.btn_raw[1] = 1'b1;
    step(D + 2);
    bus.grant[1] = 1'b1;
    step(4);
    bus.grant[1] = 1'b0;
    bus.btn_raw[1] = 1'b0;
    step(8);

    // press while serving on ch2
    bus.grant[2] = 1'b1;
    step(2);
    bus.btn_raw[2] = 1'b1;
    step(9);
    bus.grant[2] = 1'b0;
    step(8);
    bus.btn_raw[2] = 1'b0;
    step(8);

    // en low while ch0 and ch1 pending
    bus.btn_raw[1] = 1'b1;
    step(9);
    bus.en = 1'b0;
    step(2);
    bus.btn_raw[2] = 1'b1;
    step(9);
    bus.en = 1'b1;
    step(6);
    bus.btn_raw = '0;
    step(8);

    // reset mid-pending with the button held
    bus.btn_raw[0] = 1'b1;
    step(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(12);
    bus.btn_raw = '0;
    step(8);

    // random phase
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(9) == 0) bus.btn_raw[c] = ~bus.btn_raw[c];
        if ($urandom_range(24) == 0) bus.grant[c] = ~bus.grant[c];
      end
      if ($urandom_range(199) == 0) bus.en = ~bus.en;
      reset = ($urandom_range(499) == 0);
      step(1);
    end
    reset = 1'b0;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
